// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers and the column type used by the mix datapaths.
package aes_pkg;

  // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY = 8'h1B;

  // One state column; element [r] holds row r.
  typedef logic [3:0][7:0] aes_col_t;

  // Multiply by x (i.e. by 02) modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // Multiply by one of the MixColumns/InvMixColumns constants.
  // Built from the x2/x4/x8 chain, so only the constants actually used are supported.
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] res;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h02:   res = x2;
      8'h03:   res = x2 ^ b;
      8'h09:   res = x8 ^ b;
      8'h0B:   res = x8 ^ x2 ^ b;
      8'h0D:   res = x8 ^ x4 ^ b;
      8'h0E:   res = x8 ^ x4 ^ x2;
      default: res = b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gf_mix_word.sv
// Combinational MixColumns / InvMixColumns of one full column, with a pass-through
// for the final round. Shared with the parallel-datapath variant.
module gf_mix_word
  import aes_pkg::*;
(
  input  aes_col_t i_col,
  input  logic     i_inverse,
  input  logic     i_bypass,
  output aes_col_t o_col
);

  // One output row: a0 is the same row, a1..a3 the following rows (wrapping).
  function automatic logic [7:0] mix_row(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3,
                                         input logic inv);
    logic [7:0] res;
    if (inv) begin
      res = gf_mul(a0, 8'h0E) ^ gf_mul(a1, 8'h0B) ^ gf_mul(a2, 8'h0D) ^ gf_mul(a3, 8'h09);
    end else begin
      res = gf_mul(a0, 8'h02) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3;
    end
    return res;
  endfunction

  // Circulant matrix product, or the column untouched when bypassed.
  always_comb begin
    o_col = i_col;
    if (!i_bypass) begin
      o_col[0] = mix_row(i_col[0], i_col[1], i_col[2], i_col[3], i_inverse);
      o_col[1] = mix_row(i_col[1], i_col[2], i_col[3], i_col[0], i_inverse);
      o_col[2] = mix_row(i_col[2], i_col[3], i_col[0], i_col[1], i_inverse);
      o_col[3] = mix_row(i_col[3], i_col[0], i_col[1], i_col[2], i_inverse);
    end
  end

endmodule

// File: rtl/byte_mix_column_unit.sv
// Byte-serial AES MixColumns stage: gathers four row bytes, mixes the column on the
// edge that accepts row 3 (using the live row-3 byte) and drains it over four cycles.
module byte_mix_column_unit
  import aes_pkg::*;
#(
  parameter logic [7:0] OUT_IDLE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_synch,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  input  logic       inverse,
  input  logic       bypass,
  output logic       out_valid,
  output logic [7:0] out_byte
);

  logic [1:0]       r_row;
  logic [2:0][7:0]  r_col;
  logic             r_inv;
  logic             r_byp;
  aes_col_t         r_sr;
  logic [2:0]       r_cnt;

  aes_col_t         w_col;
  aes_col_t         w_mix;
  logic             w_last;

  // Rows 0..2 come from the column registers, row 3 straight from the input.
  assign w_col  = {in_byte, r_col[2], r_col[1], r_col[0]};
  assign w_last = in_valid && (r_row == 2'd3);

  gf_mix_word u_mix (
    .i_col     (w_col),
    .i_inverse (r_inv),
    .i_bypass  (r_byp),
    .o_col     (w_mix)
  );

  // ---- collection stage: row counter, column bytes and per-column mode latch ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= 2'd0;
      r_col <= '0;
      r_inv <= 1'b0;
      r_byp <= 1'b0;
    end else if (rst_synch) begin
      r_row <= 2'd0;
      r_col <= '0;
      r_inv <= 1'b0;
      r_byp <= 1'b0;
    end else if (in_valid) begin
      r_row <= r_row + 2'd1;
      case (r_row)
        2'd0: begin
          r_col[0] <= in_byte;
          r_inv    <= inverse;
          r_byp    <= bypass;
        end
        2'd1:    r_col[1] <= in_byte;
        2'd2:    r_col[2] <= in_byte;
        default: ;
      endcase
    end
  end

  // ---- drain stage: load the mixed column (load beats the last shift), then shift out ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= 3'd0;
    end else if (rst_synch) begin
      r_sr  <= '0;
      r_cnt <= 3'd0;
    end else if (w_last) begin
      r_sr  <= w_mix;
      r_cnt <= 3'd4;
    end else if (r_cnt != 3'd0) begin
      r_sr  <= {8'h00, r_sr[3:1]};
      r_cnt <= r_cnt - 3'd1;
    end
  end

  assign out_valid = (r_cnt != 3'd0);
  assign out_byte  = out_valid ? r_sr[0] : OUT_IDLE;

endmodule

// File: tb/tb_byte_mix_column_unit.sv
// Scoreboard bench for byte_mix_column_unit: expected bytes and the cycle each must
// appear in are queued when a column's row-3 byte is accepted.
module tb_byte_mix_column_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_synch;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       inverse;
  logic       bypass;
  logic       out_valid;
  logic [7:0] out_byte;

  byte_mix_column_unit dut (
    .clk       (clk),
    .rst       (rst),
    .rst_synch (rst_synch),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .inverse   (inverse),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_byte  (out_byte)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t q[$];
  exp_t e_m;
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference GF(2^8) multiply, bitwise shift-and-add.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [3:0][7:0] col(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
    logic [3:0][7:0] c;
    c[0] = b0; c[1] = b1; c[2] = b2; c[3] = b3;
    return c;
  endfunction

  function automatic logic [3:0][7:0] model(input logic [3:0][7:0] a, input logic inv,
                                            input logic byp);
    logic [3:0][7:0] o;
    logic [7:0] k[4];
    if (inv) begin k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09; end
    else     begin k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01; end
    for (int r = 0; r < 4; r++) begin
      o[r] = 8'h00;
      for (int j = 0; j < 4; j++) o[r] = o[r] ^ gm(a[(r + j) % 4], k[j]);
    end
    return byp ? a : o;
  endfunction

  // Drive one column; invm/bypm give the mode inputs per row (bit r with row r).
  task automatic send_col(input logic [3:0][7:0] a, input logic [3:0] invm,
                          input logic [3:0] bypm, input int gap,
                          input logic [3:0][7:0] exp);
    for (int r = 0; r < 4; r++) begin
      in_valid = 1'b1;
      in_byte  = a[r];
      inverse  = invm[r];
      bypass   = bypm[r];
      @(posedge clk);
      #1;
      if (r == 3) begin
        for (int k = 0; k < 4; k++) q.push_back('{b: exp[k], c: cyc + k});
      end
      in_valid = 1'b0;
      inverse  = 1'b0;
      bypass   = 1'b0;
      in_byte  = 8'h00;
      if (r < 3) repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && !rst_synch) begin
      if (out_valid) begin
        check("valid_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e_m = q.pop_front();
          check("out_byte", 32'(out_byte), 32'(e_m.b));
          check("out_cycle", 32'(cyc), 32'(e_m.c));
        end
      end else begin
        check("idle_byte", 32'(out_byte), 32'h00);
        if (q.size() != 0 && q[0].c <= cyc) begin
          check("out_valid_missing", 32'(out_valid), 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0][7:0] a;
    logic [3:0]      im;
    logic [3:0]      bm;
    rst = 1'b1; rst_synch = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    inverse = 1'b0; bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_byte", 32'(out_byte), 32'h00);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Forward single column
    send_col(col(8'hdb, 8'h13, 8'h53, 8'h45), 4'b0000, 4'b0000, 0,
             col(8'h8e, 8'h4d, 8'ha1, 8'hbc));
    repeat (6) begin @(posedge clk); #1; end

    // Back-to-back streaming columns
    send_col(col(8'hd4, 8'hbf, 8'h5d, 8'h30), 4'b0000, 4'b0000, 0,
             col(8'h04, 8'h66, 8'h81, 8'he5));
    send_col(col(8'hf2, 8'h0a, 8'h22, 8'h5c), 4'b0000, 4'b0000, 0,
             col(8'h9f, 8'hdc, 8'h58, 8'h9d));
    repeat (6) begin @(posedge clk); #1; end

    // Inverse
    send_col(col(8'h8e, 8'h4d, 8'ha1, 8'hbc), 4'b0001, 4'b0000, 0,
             col(8'hdb, 8'h13, 8'h53, 8'h45));
    // inverse toggled on row 2 only is ignored
    send_col(col(8'hc6, 8'hc6, 8'hc6, 8'hc6), 4'b0100, 4'b0000, 0,
             col(8'hc6, 8'hc6, 8'hc6, 8'hc6));
    send_col(col(8'h01, 8'h01, 8'h01, 8'h01), 4'b0100, 4'b0000, 0,
             col(8'h01, 8'h01, 8'h01, 8'h01));
    // Mode change on a non-zero row of a real column must not alter it
    send_col(col(8'hdb, 8'h13, 8'h53, 8'h45), 4'b1110, 4'b0110, 0,
             col(8'h8e, 8'h4d, 8'ha1, 8'hbc));
    repeat (6) begin @(posedge clk); #1; end

    // Bypass with 2-cycle gaps
    send_col(col(8'h11, 8'h22, 8'h33, 8'h44), 4'b0000, 4'b1111, 2,
             col(8'h11, 8'h22, 8'h33, 8'h44));
    repeat (6) begin @(posedge clk); #1; end

    // Synchronous clear after two bytes of a column
    in_valid = 1'b1; in_byte = 8'hdb; @(posedge clk); #1;
    in_byte = 8'h13; @(posedge clk); #1;
    in_valid = 1'b0; rst_synch = 1'b1; @(posedge clk); #1;
    check("rst_synch_valid", 32'(out_valid), 32'd0);
    rst_synch = 1'b0;
    send_col(col(8'hf2, 8'h0a, 8'h22, 8'h5c), 4'b0000, 4'b0000, 0,
             col(8'h9f, 8'hdc, 8'h58, 8'h9d));
    repeat (6) begin @(posedge clk); #1; end

    // Async reset in the middle of a drain
    send_col(col(8'hdb, 8'h13, 8'h53, 8'h45), 4'b0000, 4'b0000, 0,
             col(8'h8e, 8'h4d, 8'ha1, 8'hbc));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_byte", 32'(out_byte), 32'h00);
    q.delete();
    @(posedge clk); #1;
    check("arst_hold_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    send_col(col(8'hf2, 8'h0a, 8'h22, 8'h5c), 4'b0000, 4'b0000, 0,
             col(8'h9f, 8'hdc, 8'h58, 8'h9d));

    // Random columns against the reference model
    for (int n = 0; n < 12; n++) begin
      for (int r = 0; r < 4; r++) a[r] = 8'($urandom_range(0, 255));
      im = 4'($urandom_range(0, 15));
      bm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      send_col(a, im, bm, $urandom_range(0, 2), model(a, im[0], bm[0]));
    end

    repeat (8) begin @(posedge clk); #1; end
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_mix_column_unit.md
Name: byte_mix_column_unit

Overview:
Byte-serial AES MixColumns / InvMixColumns stage that sits directly downstream of the byte permutation (ShiftRows) unit. It collects one 4-byte state column per group of accepted bytes, in row 0..3 order. It then emits the mixed column byte-serially with a fixed latency. A per-column bypass serves the final round, which has no MixColumns, so the datapath stays uniform across rounds.

Parameters:
OUT_IDLE, 8'h00, value driven on out_byte while out_valid is low

Ports:
clk        input   1  system clock, all state updates on posedge
rst        input   1  asynchronous active-high reset
rst_synch  input   1  synchronous clear, same effect as rst, sampled on posedge clk
in_valid   input   1  in_byte carries a state byte this cycle
in_byte    input   8  state byte, column-major, row 0 first
inverse    input   1  1 = InvMixColumns (decrypt), 0 = MixColumns; sampled with the row-0 byte
bypass     input   1  1 = pass the column unchanged (last round); sampled with the row-0 byte
out_valid  output  1  out_byte carries a processed byte
out_byte   output  8  processed byte, same column/row order as input

Behaviour:
- Reset (rst async, or rst_synch at the edge), in priority over all other inputs:
  - row counter = 0; column regs = 0; output shift register = 0; output count = 0.
  - out_valid = 0; out_byte = OUT_IDLE.
- Input collection:
  - On a posedge with in_valid=1, the byte is stored in col_reg[row] and row increments mod 4.
  - in_valid=0 stalls the row counter; no bubble limit applies.
  - inverse and bypass are latched only when row==0 is accepted. Changes on rows 1-3 are ignored for that column.
- Column completion, at the edge accepting row 3:
  - mix result = f(col_reg[0..2], in_byte), combinational from the live in_byte.
  - The result loads the 4-byte output shift register; output count = 4.
- Output:
  - While output count > 0: out_valid = 1 and out_byte = shift register head.
  - Each posedge shifts the head out and decrements the count. This occurs every cycle regardless of in_valid.
  - When the count reaches 0, out_valid = 0 and out_byte = OUT_IDLE.
- Latency:
  - A byte of row i sampled at edge Ei appears on out_byte in the cycle after edge E(i+3).
  - For gap-free input this is exactly 3 cycles for every byte, and output is continuous with no gaps.
- Overflow:
  - Impossible by construction, because a new load needs 4 accepted bytes and the drain takes 4 cycles.
  - When a load and the final shift of the previous column coincide at one edge, the load wins and the count becomes 4.
- Arithmetic, in GF(2^8) with reduction polynomial 0x11B (xtime: shift left, XOR 0x1B if bit 7 was set):
  - forward: o_r = 2*a_r ^ 3*a_(r+1) ^ a_(r+2) ^ a_(r+3), indices mod 4.
  - inverse: o_r = 0E*a_r ^ 0B*a_(r+1) ^ 0D*a_(r+2) ^ 09*a_(r+3).
  - bypass: o_r = a_r; inverse is ignored.
- Reset mid-column:
  - The partial column is discarded, output drains immediately (out_valid = 0 the next cycle), and the next accepted byte is row 0.
- No backpressure: the downstream stage must accept out_byte whenever out_valid = 1.

Decomposition:
- Shared package aes_pkg:
  - AES_POLY = 8'h1B
  - function xtime(byte)
  - function gf_mul(byte, const) for constants 02, 03, 09, 0B, 0D, 0E
  - typedef aes_col_t = 4 x 8-bit array
- Sub-module gf_mix_word: combinational, inputs aes_col_t + inverse + bypass, output aes_col_t. It is reused by the parallel-datapath variant.
- byte_mix_column_unit holds only the counters, column regs, latches and output shift register.

Test Plan:
- Forward, gap-free, inverse=0, bypass=0: db 13 53 45 → out_valid high 4 cycles, 3-cycle latency, out 8e 4d a1 bc.
- Streaming columns: d4 bf 5d 30 then f2 0a 22 5c back-to-back → 04 66 81 e5 9f dc 58 9d with no out_valid gap.
- Inverse: 8e 4d a1 bc with inverse=1 on row 0 → db 13 53 45.
- Toggle inverse high on row 2 only: column c6 c6 c6 c6 and column 01 01 01 01 → forward result unchanged (c6 c6 c6 c6, 01 01 01 01).
- Bypass plus gaps: bypass=1, bytes 11 22 33 44 with in_valid low 2 cycles between each → out 11 22 33 44, each appearing 3 cycles after the row-3 edge sequence described above.
- rst_synch asserted after 2 bytes of db 13 53 45, then full column f2 0a 22 5c → no output for the partial column, then 9f dc 58 9d. Async rst pulse mid-drain → out_valid=0 and out_byte=8'h00 immediately.
